// File: rtl/ram_bus_mux.sv
// rtl/ram_bus_mux.sv - phi0 time-multiplexer of the system RAM between VIC-II fetches and 6510 accesses
// Phase 1 is always a VIC read; phase 2 goes to the CPU unless aec lets the VIC steal it.
module ram_bus_mux #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PHASE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  phi0,
  input  logic [ADDR_WIDTH-1:0] vic_a,
  input  logic                  vic_aec,
  output logic [DATA_WIDTH-1:0] vic_do,
  output logic                  vic_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_a,
  input  logic [DATA_WIDTH-1:0] cpu_di,
  output logic [DATA_WIDTH-1:0] cpu_do,
  output logic                  cpu_done,
  output logic                  ram_enable,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam int CW = $clog2(2 * PHASE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(2 * PHASE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PH2   = CW'(PHASE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP1  = CW'(2);
  localparam logic [CW-1:0] CNT_CAP2  = CW'(PHASE_CYCLES + 2);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_VIC,
    OWN_CPU
  } owner_t;

  owner_t        owner;
  logic          owner_we;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      phi0       <= 1'b0;
      owner      <= OWN_IDLE;
      owner_we   <= 1'b0;
      ram_enable <= 1'b0;
      ram_we     <= 1'b0;
      ram_a      <= '0;
      ram_di     <= '0;
      vic_do     <= '0;
      vic_valid  <= 1'b0;
      cpu_do     <= '0;
      cpu_done   <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      phi0       <= (cnt_next >= CNT_PH2);
      ram_enable <= 1'b0;
      ram_we     <= 1'b0;
      vic_valid  <= 1'b0;
      cpu_done   <= 1'b0;

      if (cnt == '0) begin
        owner      <= OWN_VIC;
        owner_we   <= 1'b0;
        ram_enable <= 1'b1;
        ram_a      <= vic_a;
        ram_di     <= '0;
      end else if (cnt == CNT_PH2) begin
        if (!vic_aec) begin
          owner      <= OWN_VIC;
          owner_we   <= 1'b0;
          ram_enable <= 1'b1;
          ram_a      <= vic_a;
          ram_di     <= '0;
        end else if (cpu_req) begin
          owner      <= OWN_CPU;
          owner_we   <= cpu_we;
          ram_enable <= 1'b1;
          ram_we     <= cpu_we;
          ram_a      <= cpu_a;
          ram_di     <= cpu_we ? cpu_di : '0;
        end else begin
          owner    <= OWN_IDLE;
          owner_we <= 1'b0;
        end
      end else if (cnt == CNT_CAP1 || cnt == CNT_CAP2) begin
        // The RAM's registered output is valid one cycle after the enable cycle.
        case (owner)
          OWN_VIC: begin
            vic_do    <= ram_do;
            vic_valid <= 1'b1;
          end
          OWN_CPU: begin
            if (!owner_we) cpu_do <= ram_do;
            cpu_done <= 1'b1;
          end
          default: ;
        endcase
        owner <= OWN_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_mux.sv
// tb/tb_ram_bus_mux.sv - randomized self-checking bench for ram_bus_mux against a per-period schedule model
module tb_ram_bus_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        phi0;
  logic [15:0] vic_a;
  logic        vic_aec;
  logic [7:0]  vic_do;
  logic        vic_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        cpu_done;
  logic        ram_enable;
  logic        ram_we;
  logic [15:0] ram_a;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do = 8'h00;

  int checks = 0;
  int passes = 0;

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] exp_vdo;
  logic [7:0] exp_cdo;

  logic       s_en  [0:7];
  logic       s_we  [0:7];
  logic       s_vv  [0:7];
  logic       s_cd  [0:7];
  logic       s_phi [0:7];
  logic [15:0] s_a  [0:7];
  logic [7:0] s_vdo [0:7];
  logic [7:0] s_cdo [0:7];

  ram_bus_mux #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .PHASE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .phi0(phi0),
    .vic_a(vic_a), .vic_aec(vic_aec), .vic_do(vic_do), .vic_valid(vic_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_done(cpu_done),
    .ram_enable(ram_enable), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM; output forced to 0 when not enabled.
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_we) begin
        ram[ram_a] <= ram_di;
        ram_do     <= 8'h00;
      end else begin
        ram_do <= ram[ram_a];
      end
    end else begin
      ram_do <= 8'h00;
    end
  end

  // One full phi0 period starting just before the cnt==0 edge; checks every cycle against the model.
  task automatic run_period(input bit aec, input bit req, input bit we, input logic [15:0] ca,
                            input logic [7:0] cd, input logic [15:0] va1, input logic [15:0] va2,
                            input bit noise);
    int c;
    bit cpu_slot, e_en, e_we, e_vv, e_cd, e_phi;
    logic [15:0] e_a;
    logic [7:0]  e_di;
    cpu_slot = aec && req;
    for (int k = 0; k < 8; k++) begin
      if (noise) begin
        vic_a = 16'($urandom); vic_aec = 1'b1; cpu_req = 1'b1;
        cpu_we = 1'($urandom); cpu_a = 16'($urandom); cpu_di = 8'($urandom);
      end
      if (k == 0) vic_a = va1;
      if (k == 4) begin
        vic_a = va2; vic_aec = aec; cpu_req = req; cpu_we = we; cpu_a = ca; cpu_di = cd;
      end
      @(posedge clk);
      #1;
      c = (k + 1) % 8;
      e_phi = (c >= 4);
      e_en  = (c == 1) || (c == 5 && (!aec || req));
      e_we  = (c == 5) && cpu_slot && we;
      e_a   = (c == 1) ? va1 : (cpu_slot ? ca : va2);
      e_di  = ((c == 5) && cpu_slot && we) ? cd : 8'h00;
      e_vv  = (c == 3) || (c == 7 && !aec);
      e_cd  = (c == 7) && cpu_slot;
      if (c == 3) exp_vdo = ref_mem[va1];
      if (c == 7 && !aec) exp_vdo = ref_mem[va2];
      if (c == 7 && cpu_slot) begin
        if (we) ref_mem[ca] = cd;
        else exp_cdo = ref_mem[ca];
      end
      s_en[c] = ram_enable; s_we[c] = ram_we; s_vv[c] = vic_valid; s_cd[c] = cpu_done;
      s_phi[c] = phi0; s_a[c] = ram_a; s_vdo[c] = vic_do; s_cdo[c] = cpu_do;

      checks++; if (phi0 !== e_phi) $display("FAIL phi0 cnt=%0d got %b want %b", c, phi0, e_phi); else passes++;
      checks++; if (ram_enable !== e_en) $display("FAIL ram_enable cnt=%0d got %b want %b", c, ram_enable, e_en); else passes++;
      checks++; if (ram_we !== e_we) $display("FAIL ram_we cnt=%0d got %b want %b", c, ram_we, e_we); else passes++;
      checks++; if (vic_valid !== e_vv) $display("FAIL vic_valid cnt=%0d got %b want %b", c, vic_valid, e_vv); else passes++;
      checks++; if (cpu_done !== e_cd) $display("FAIL cpu_done cnt=%0d got %b want %b", c, cpu_done, e_cd); else passes++;
      checks++; if (vic_do !== exp_vdo) $display("FAIL vic_do cnt=%0d got %h want %h", c, vic_do, exp_vdo); else passes++;
      checks++; if (cpu_do !== exp_cdo) $display("FAIL cpu_do cnt=%0d got %h want %h", c, cpu_do, exp_cdo); else passes++;
      if (e_en) begin
        checks++; if (ram_a !== e_a) $display("FAIL ram_a cnt=%0d got %h want %h", c, ram_a, e_a); else passes++;
        checks++; if (ram_di !== e_di) $display("FAIL ram_di cnt=%0d got %h want %h", c, ram_di, e_di); else passes++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vic_a = 16'h0; vic_aec = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 16'h0; cpu_di = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (phi0 !== 1'b0) $display("FAIL reset_phi0 got %b want 0", phi0); else passes++;
    checks++; if (ram_enable !== 1'b0 || ram_we !== 1'b0) $display("FAIL reset_ram_ctl got %b%b want 00", ram_enable, ram_we); else passes++;
    checks++; if (ram_a !== 16'h0 || ram_di !== 8'h0) $display("FAIL reset_ram_bus got %h/%h want 0000/00", ram_a, ram_di); else passes++;
    checks++; if (vic_do !== 8'h0 || cpu_do !== 8'h0) $display("FAIL reset_data got %h/%h want 00/00", vic_do, cpu_do); else passes++;
    checks++; if (vic_valid !== 1'b0 || cpu_done !== 1'b0) $display("FAIL reset_pulses got %b%b want 00", vic_valid, cpu_done); else passes++;
    reset = 1'b0;
    exp_vdo = 8'h00;
    exp_cdo = 8'h00;
  endtask

  task automatic test_vic_fetch();
    int highs;
    ram[16'h0400] = 8'h41; ref_mem[16'h0400] = 8'h41;
    run_period(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 16'h0400, 16'h0400, 1'b0);
    checks++; if (s_en[1] !== 1'b1 || s_a[1] !== 16'h0400) $display("FAIL vic_fetch_addr got %b/%h want 1/0400", s_en[1], s_a[1]); else passes++;
    checks++; if (s_vv[3] !== 1'b1 || s_vdo[3] !== 8'h41) $display("FAIL vic_fetch_data got %b/%h want 1/41", s_vv[3], s_vdo[3]); else passes++;
    highs = 0;
    for (int i = 0; i < 8; i++) highs += int'(s_phi[i]);
    checks++; if (highs != 4) $display("FAIL phi0_duty got %0d want 4", highs); else passes++;
  endtask

  task automatic test_cpu_write_read();
    run_period(1'b1, 1'b1, 1'b1, 16'hC000, 8'h5A, 16'h0400, 16'h0401, 1'b0);
    checks++; if (s_we[5] !== 1'b1 || s_cd[7] !== 1'b1) $display("FAIL cpu_write got we=%b done=%b want 1/1", s_we[5], s_cd[7]); else passes++;
    run_period(1'b1, 1'b1, 1'b0, 16'hC000, 8'hFF, 16'h0400, 16'h0401, 1'b0);
    checks++; if (s_we[5] !== 1'b0 || s_cd[7] !== 1'b1) $display("FAIL cpu_read got we=%b done=%b want 0/1", s_we[5], s_cd[7]); else passes++;
    checks++; if (s_cdo[7] !== 8'h5A) $display("FAIL cpu_readback got %h want 5a", s_cdo[7]); else passes++;
  endtask

  task automatic test_vic_steal();
    int nv, nd, nw;
    run_period(1'b0, 1'b1, 1'b1, 16'hC001, 8'h77, 16'h0400, 16'hC000, 1'b0);
    nv = 0; nd = 0; nw = 0;
    for (int i = 0; i < 8; i++) begin
      nv += int'(s_vv[i]); nd += int'(s_cd[i]); nw += int'(s_we[i]);
    end
    checks++; if (nv != 2 || nd != 0 || nw != 0) $display("FAIL vic_steal got valid=%0d done=%0d we=%0d want 2/0/0", nv, nd, nw); else passes++;
    checks++; if (s_vdo[7] !== 8'h5A) $display("FAIL vic_steal_data got %h want 5a", s_vdo[7]); else passes++;
  endtask

  task automatic test_idle_phase2();
    logic [7:0] held;
    held = exp_cdo;
    run_period(1'b1, 1'b0, 1'b1, 16'hC000, 8'h11, 16'h0400, 16'h0400, 1'b0);
    checks++; if ({s_en[4], s_en[5], s_en[6], s_en[7]} !== 4'b0000) $display("FAIL idle_enable got %b%b%b%b want 0000", s_en[4], s_en[5], s_en[6], s_en[7]); else passes++;
    checks++; if (s_cdo[7] !== held || s_cd[7] !== 1'b0) $display("FAIL idle_hold got %h/%b want %h/0", s_cdo[7], s_cd[7], held); else passes++;
  endtask

  task automatic test_late_req();
    int nd;
    run_period(1'b1, 1'b0, 1'b0, 16'hC000, 8'h00, 16'h0400, 16'h0400, 1'b1);
    nd = 0;
    for (int i = 0; i < 8; i++) nd += int'(s_cd[i]);
    checks++; if (nd != 0 || s_en[5] !== 1'b0) $display("FAIL late_req got done=%0d en5=%b want 0/0", nd, s_en[5]); else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_period(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                 16'hC000 + 16'($urandom_range(0, 3)), 8'($urandom),
                 16'hC000 + 16'($urandom_range(0, 5)), 16'hC000 + 16'($urandom_range(0, 5)),
                 ($urandom % 3) == 0);
    end
  endtask

  task automatic test_reset_mid_slot();
    vic_a = 16'h0400; vic_aec = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 16'hC000; cpu_di = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (ram_enable !== 1'b1) $display("FAIL midslot_inflight got %b want 1", ram_enable); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (phi0 !== 1'b0 || ram_enable !== 1'b0 || ram_we !== 1'b0) $display("FAIL midslot_ctl got %b%b%b want 000", phi0, ram_enable, ram_we); else passes++;
    checks++; if (ram_a !== 16'h0 || ram_di !== 8'h0 || vic_do !== 8'h0 || cpu_do !== 8'h0) $display("FAIL midslot_data got %h/%h/%h/%h want zeros", ram_a, ram_di, vic_do, cpu_do); else passes++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++; if (cpu_done !== 1'b0 || vic_valid !== 1'b0) $display("FAIL midslot_pulse got %b%b want 00", cpu_done, vic_valid); else passes++;
    end
    reset = 1'b0;
    exp_vdo = 8'h00;
    exp_cdo = 8'h00;
    checks++; if (phi0 !== 1'b0) $display("FAIL post_reset_phi0 got %b want 0", phi0); else passes++;
    run_period(1'b1, 1'b1, 1'b0, 16'hC000, 8'h00, 16'h0400, 16'h0400, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    test_reset();
    test_vic_fetch();
    test_cpu_write_read();
    test_vic_steal();
    test_idle_phase2();
    test_late_req();
    test_random();
    test_reset_mid_slot();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
